// File: rtl/counter_to_t_sub1.sv
// counter_to_t_sub1: modulo up/down index counter over 0..t_sub_1 with wrap detection
//   clk      rising-edge clock
//   rst      asynchronous active-high reset, clears o_cnt
//   ce       count enable
//   inc      direction, 1 = up, 0 = down
//   t_sub_1  terminal index (t-1), may change any cycle
//   o_cnt    registered count
//   o_last   terminal value for the current direction reached
//   o_wrap   o_last & ce, next edge wraps
// Optional macro COUNTER_SATURATE_EN: saturate at the ends instead of wrapping, o_wrap forced to 0.
module counter_to_t_sub1 #(
  parameter int DATA_WIDTH = 8,
  localparam int CW = $clog2(DATA_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          inc,
  input  logic [CW-1:0] t_sub_1,
  output logic [CW-1:0] o_cnt,
  output logic          o_last,
  output logic          o_wrap
);
  logic          at_top;
  logic          at_zero;
  logic [CW-1:0] nxt;
  always_comb begin
    at_top  = o_cnt >= t_sub_1;
    at_zero = o_cnt == '0;
    o_last  = inc ? at_top : at_zero;
`ifdef COUNTER_SATURATE_EN
    nxt     = inc ? (at_top ? t_sub_1 : o_cnt + 1'b1) : (at_zero ? '0 : o_cnt - 1'b1);
    o_wrap  = 1'b0;
`else
    // a count above the limit (limit lowered mid-run) reloads the limit when counting down
    nxt     = inc ? (at_top ? '0 : o_cnt + 1'b1) : ((at_zero || o_cnt > t_sub_1) ? t_sub_1 : o_cnt - 1'b1);
    o_wrap  = o_last & ce;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) o_cnt <= '0;
    else if (ce) o_cnt <= nxt;
endmodule

// File: tb/tb_counter_to_t_sub1.sv
// tb_counter_to_t_sub1: directed bench for counter_to_t_sub1 with a behavioural reference model
module tb_counter_to_t_sub1;
  logic       clk = 0;
  logic       rst = 1;
  logic       ce = 0;
  logic       inc = 1;
  logic [2:0] t_sub_1 = 3'd4;
  logic [2:0] o_cnt;
  logic       o_last;
  logic       o_wrap;
  int vectors = 0;
  int miscompares = 0;
  int m = 0;
  bit chk = 0;
`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1;
`else
  localparam bit SAT = 0;
`endif

  counter_to_t_sub1 #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .inc(inc), .t_sub_1(t_sub_1),
    .o_cnt(o_cnt), .o_last(o_last), .o_wrap(o_wrap)
  );

  always #5 clk = ~clk;

  function automatic int model_next(int c, int t, bit up);
    if (SAT) return up ? ((c >= t) ? t : c + 1) : ((c == 0) ? 0 : c - 1);
    if (up) return (c > t) ? 0 : (c + 1) % (t + 1);
    return (c == 0 || c > t) ? t : c - 1;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) m = 0;
    else if (ce) m = model_next(m, int'(t_sub_1), inc);

  always @(negedge clk) if (chk) begin
    bit el;
    el = inc ? (m >= int'(t_sub_1)) : (m == 0);
    vectors++;
    if (int'(o_cnt) != m || o_last !== el || o_wrap !== (el & ce & !SAT)) begin
      miscompares++;
      $display("FAIL model t=%0t cnt=%0d/%0d last=%b/%b wrap=%b/%b (got/exp)",
               $time, o_cnt, m, o_last, el, o_wrap, el & ce & !SAT);
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int up_seq[7];
  int dn_seq[6];
  int vt[8];
  bit vi[8];
  bit vc[8];

  initial begin
    up_seq = SAT ? '{1, 2, 3, 4, 4, 4, 4} : '{1, 2, 3, 4, 0, 1, 2};
    dn_seq = SAT ? '{0, 0, 0, 0, 0, 0} : '{4, 3, 2, 1, 0, 4};
    vt = '{5, 5, 5, 2, 2, 6, 1, 3};
    vi = '{1, 0, 0, 1, 0, 1, 0, 1};
    vc = '{1, 1, 0, 1, 1, 1, 1, 1};
    #1 chk = 1;
    repeat (2) step();
    rst = 0;
    lit("reset_cnt", o_cnt, 0);
    repeat (3) step();
    lit("hold_ce0", o_cnt, 0);
    ce = 1;
    for (int i = 0; i < 7; i++) begin
      step();
      lit($sformatf("up_seq%0d", i), o_cnt, up_seq[i]);
      if (i == 3) begin
        lit("up_last_at4", o_last, 1);
        lit("up_wrap_at4", o_wrap, SAT ? 0 : 1);
      end
      if (i == 2) lit("up_wrap_at3", o_wrap, 0);
    end
    ce = 0;
    step();
    lit("hold_after_up", o_cnt, up_seq[6]);
    lit("wrap_ce0", o_wrap, 0);
    rst = 1;
    #1 lit("async_rst", o_cnt, 0);
    rst = 0;
    inc = 0;
    ce = 1;
    #1 lit("down_last_at0", o_last, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      lit($sformatf("dn_seq%0d", i), o_cnt, dn_seq[i]);
    end
    t_sub_1 = 0;
    inc = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      lit($sformatf("t0_cnt%0d", i), o_cnt, 0);
      lit($sformatf("t0_last%0d", i), o_last, 1);
      lit($sformatf("t0_wrap%0d", i), o_wrap, SAT ? 0 : 1);
    end
    t_sub_1 = 7;
    repeat (6) step();
    lit("count_to6", o_cnt, 6);
    t_sub_1 = 3;
    step();
    lit("lower_limit", o_cnt, SAT ? 3 : 0);
    #2 rst = 1;
    #1 lit("mid_rst", o_cnt, 0);
    rst = 0;
    step();
    lit("resume_after_rst", o_cnt, 1);
    for (int i = 0; i < 8; i++) begin
      t_sub_1 = 3'(vt[i]);
      inc = vi[i];
      ce = vc[i];
      step();
    end
    repeat (2) step();
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
